lsu: RTL and testbench



---
 rtl/lsu.sv | 184 ++++++++++++++++++
 tb/tb_lsu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-outstanding word bus with byte strobes, IDLE/BUS/RESP sequencing.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into an immediate flagged response.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        alucode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              misaligned,
  output logic              stall
);

  // Memory alucode values, mirroring define.vh
  localparam logic [5:0] ALU_LB  = 6'd10;
  localparam logic [5:0] ALU_LH  = 6'd11;
  localparam logic [5:0] ALU_LW  = 6'd12;
  localparam logic [5:0] ALU_LBU = 6'd13;
  localparam logic [5:0] ALU_LHU = 6'd14;
  localparam logic [5:0] ALU_SB  = 6'd15;
  localparam logic [5:0] ALU_SH  = 6'd16;
  localparam logic [5:0] ALU_SW  = 6'd17;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
`endif

  logic        is_byte, is_half, is_word, is_store, is_mem, req_mis;
  logic [1:0]  req_off;
  logic [3:0]  req_strb;
  logic [31:0] req_wdata;
  logic [31:0] rd_shift, load_ext;

  // Request decode and lane placement
  always_comb begin
    is_byte  = (alucode == ALU_LB) || (alucode == ALU_LBU) || (alucode == ALU_SB);
    is_half  = (alucode == ALU_LH) || (alucode == ALU_LHU) || (alucode == ALU_SH);
    is_word  = (alucode == ALU_LW) || (alucode == ALU_SW);
    is_store = (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
    is_mem   = is_byte || is_half || is_word;
    req_mis  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    req_off  = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
    req_strb  = 4'b0000;
    req_wdata = 32'h0;
    if (is_store) begin
      if (is_word) begin
        req_strb  = 4'b1111;
        req_wdata = store_data;
      end else if (is_half) begin
        req_strb  = 4'b0011 << req_off;
        req_wdata = {16'h0, store_data[15:0]} << {req_off, 3'b000};
      end else begin
        req_strb  = 4'b0001 << req_off;
        req_wdata = {24'h0, store_data[7:0]} << {req_off, 3'b000};
      end
    end
  end

  // Lane extraction and extension of the returned word
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      ALU_LB:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      ALU_LBU: load_ext = {24'h0, rd_shift[7:0]};
      ALU_LH:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      ALU_LHU: load_ext = {16'h0, rd_shift[15:0]};
      ALU_LW:  load_ext = mem_rdata;
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    baddr_d = baddr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && is_mem) begin
          op_d    = alucode;
          off_d   = req_off;
          baddr_d = {addr[ADDR_W-1:2], 2'b00};
          we_d    = is_store;
          wstrb_d = req_strb;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_d   = req_mis;
          state_d = req_mis ? S_RESP : S_BUS;
`else
          state_d = S_BUS;
`endif
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      off_q   <= 2'b00;
      baddr_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      baddr_q <= baddr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Bus and response outputs are gated by state so they read 0 outside their phase
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    stall      = ~req_ready;
    mem_req    = (state_q == S_BUS);
    mem_we     = mem_req && we_q;
    mem_addr   = mem_req ? baddr_q : '0;
    mem_wdata  = mem_req ? wdata_q : 32'h0;
    mem_wstrb  = mem_req ? wstrb_q : 4'b0000;
    resp_valid = (state_q == S_RESP);
    resp_data  = resp_valid ? rdata_q : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = resp_valid && mis_q;
`else
    misaligned = 1'b0;
`endif
  end

  logic unused_req_mis;
  assign unused_req_mis = req_mis;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected responses, a negedge monitor pops and compares.
// Exercises both builds depending on LSU_MISALIGN_TRAP_EN.
module tb_lsu;

  localparam logic [5:0] ALU_LB  = 6'd10;
  localparam logic [5:0] ALU_LH  = 6'd11;
  localparam logic [5:0] ALU_LW  = 6'd12;
  localparam logic [5:0] ALU_LBU = 6'd13;
  localparam logic [5:0] ALU_LHU = 6'd14;
  localparam logic [5:0] ALU_SB  = 6'd15;
  localparam logic [5:0] ALU_SH  = 6'd16;
  localparam logic [5:0] ALU_SW  = 6'd17;
  localparam logic [5:0] ALU_ADD = 6'd18;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        misaligned;
  logic        stall;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .alucode(alucode), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .misaligned(misaligned), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got data %h mis %b expected none", resp_data, misaligned);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.d);
        check("misaligned", {31'h0, misaligned}, {31'h0, e.m});
        $display("resp data=%h mis=%b", resp_data, misaligned);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [5:0] code, input logic [31:0] a,
                       input logic [31:0] sd, input int dly, input logic [31:0] rd,
                       input bit mis, input logic [31:0] e_addr, input bit e_we,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_data);
    check({nm, "_ready"}, {31'h0, req_ready}, 32'h1);
    if (mis && TRAP) exp_q.push_back('{d: 32'h0, m: 1'b1});
    else             exp_q.push_back('{d: e_data, m: 1'b0});
    req_valid = 1'b1; alucode = code; addr = a; store_data = sd;
    tick();
    req_valid = 1'b0; alucode = ALU_ADD; addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
    if (mis && TRAP) begin
      check({nm, "_trap_noreq"}, {31'h0, mem_req}, 32'h0);
      check({nm, "_trap_resp"}, {31'h0, resp_valid}, 32'h1);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        check({nm, "_mem_req"}, {31'h0, mem_req}, 32'h1);
        check({nm, "_stall"}, {31'h0, stall}, 32'h1);
        check({nm, "_mem_addr"}, mem_addr, e_addr);
        check({nm, "_mem_we"}, {31'h0, mem_we}, {31'h0, e_we});
        check({nm, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, e_strb});
        if (e_we) check({nm, "_mem_wdata"}, mem_wdata, e_wdata);
        if (i == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        tick();
      end
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      check({nm, "_req_drop"}, {31'h0, mem_req}, 32'h0);
      check({nm, "_resp_pulse"}, {31'h0, resp_valid}, 32'h1);
    end
    tick();
    check({nm, "_resp_once"}, {31'h0, resp_valid}, 32'h0);
    check({nm, "_ready_back"}, {31'h0, req_ready}, 32'h1);
    $display("op %s code=%0d addr=%h done", nm, code, a);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_resp", {31'h0, resp_valid}, 32'h0);
    $display("reset checked");

    // Non-memory op is ignored
    req_valid = 1'b1; alucode = ALU_ADD; addr = 32'h1000;
    tick();
    req_valid = 1'b0;
    check("nonmem_noreq", {31'h0, mem_req}, 32'h0);
    check("nonmem_ready", {31'h0, req_ready}, 32'h1);
    tick();
    $display("non-memory op ignored");

    do_op("LB",  ALU_LB,  32'h1003, 32'h0, 0, 32'h80FF1234, 0, 32'h1000, 0, 4'h0, 32'h0, 32'hFFFFFF80);
    do_op("LBU", ALU_LBU, 32'h1003, 32'h0, 0, 32'h80FF1234, 0, 32'h1000, 0, 4'h0, 32'h0, 32'h00000080);
    do_op("LB1", ALU_LB,  32'h1001, 32'h0, 1, 32'h00007F00, 0, 32'h1000, 0, 4'h0, 32'h0, 32'h0000007F);
    do_op("LH",  ALU_LH,  32'h1002, 32'h0, 0, 32'hBEEF0000, 0, 32'h1000, 0, 4'h0, 32'h0, 32'hFFFFBEEF);
    do_op("LHU", ALU_LHU, 32'h1002, 32'h0, 0, 32'hBEEF0000, 0, 32'h1000, 0, 4'h0, 32'h0, 32'h0000BEEF);
    do_op("SB",  ALU_SB,  32'h2001, 32'h123456AB, 0, 32'hFFFFFFFF, 0, 32'h2000, 1, 4'b0010, 32'h0000AB00, 32'h0);
    do_op("SH",  ALU_SH,  32'h2002, 32'h0000BEEF, 2, 32'hFFFFFFFF, 0, 32'h2000, 1, 4'b1100, 32'hBEEF0000, 32'h0);
    do_op("LW",  ALU_LW,  32'h3000, 32'h0, 3, 32'hCAFEF00D, 0, 32'h3000, 0, 4'h0, 32'h0, 32'hCAFEF00D);
    do_op("SWmis", ALU_SW, 32'h2002, 32'hDEADBEEF, 0, 32'h0, 1, 32'h2000, 1, 4'hF, 32'hDEADBEEF, 32'h0);
    do_op("LHmis", ALU_LH, 32'h1001, 32'h0, 0, 32'h00008001, 1, 32'h1000, 0, 4'h0, 32'h0, 32'hFFFF8001);

    // Reset while in BUS discards the op; a late ack is ignored
    req_valid = 1'b1; alucode = ALU_LW; addr = 32'h4000;
    tick();
    req_valid = 1'b0;
    check("rstbus_inbus", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstbus_req", {31'h0, mem_req}, 32'h0);
    check("rstbus_ready", {31'h0, req_ready}, 32'h1);
    check("rstbus_noresp", {31'h0, resp_valid}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    check("lateack_noresp", {31'h0, resp_valid}, 32'h0);
    check("lateack_ready", {31'h0, req_ready}, 32'h1);
    tick();
    check("lateack_noresp2", {31'h0, resp_valid}, 32'h0);
    $display("reset during BUS checked");

    do_op("LBpost", ALU_LB, 32'h5000, 32'h0, 0, 32'h000000F0, 0, 32'h5000, 0, 4'h0, 32'h0, 32'hFFFFFFF0);

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
